// File: rtl/query_batch_scheduler.sv
// ---------------------------------------------------------------------------
// query_batch_scheduler
//
// Purpose: queues NFA query jobs and issues them one at a time to a single
// processing channel. For each job at the head of the queue the scheduler:
//   - decides whether the channel must reload its NFA (hash differs from the
//     last launched one, or nothing has been launched yet);
//   - rejects jobs whose query length (or, when reloading, NFA length) is
//     zero or not a multiple of 64 bytes;
//   - launches accepted jobs with a one-cycle ch_start pulse;
//   - waits for ch_done;
//   - reports every job, rejected or not, on the completion handshake.
//
// Optional feature: define ERBIUM_SCHED_PERF_EN to add the cmpl_cycles
// output. It holds the LAUNCH-to-ch_done cycle count, inclusive of both
// cycles and saturating at 32 bits. It is zero for rejected jobs.
//
// Ports
//   data_clk, areset            clock, asynchronous active-high reset
//   job_valid/job_ready         job submit handshake
//   job_id, job_nfa_hash        job tag and NFA hash
//   job_nfa_ptr/_bytes          NFA base address / length in bytes
//   job_query_ptr/_bytes        query base address / length in bytes
//   ch_start, ch_done           channel start pulse out, completion pulse in
//   ch_*                        head-of-queue descriptor presented to channel
//   cmpl_valid/cmpl_ready       completion handshake
//   cmpl_id, cmpl_err           tag of completing job, rejected flag
//   busy                        FSM not in IDLE
//   q_level                     queue occupancy
//   jobs_done                   completion counter (wraps)
//   cmpl_cycles                 (ERBIUM_SCHED_PERF_EN only) launch latency
// ---------------------------------------------------------------------------
module query_batch_scheduler #(
  parameter int ADDR_W  = 64,
  parameter int XFER_W  = 64,
  parameter int Q_DEPTH = 4
) (
  input  logic                         data_clk,
  input  logic                         areset,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [7:0]                   job_id,
  input  logic [63:0]                  job_nfa_hash,
  input  logic [ADDR_W-1:0]            job_nfa_ptr,
  input  logic [XFER_W-1:0]            job_nfa_bytes,
  input  logic [ADDR_W-1:0]            job_query_ptr,
  input  logic [XFER_W-1:0]            job_query_bytes,
  output logic                         ch_start,
  input  logic                         ch_done,
  output logic [63:0]                  ch_nfa_hash,
  output logic [ADDR_W-1:0]            ch_nfadata_ptr,
  output logic [XFER_W-1:0]            ch_nfa_xfer_size_in_bytes,
  output logic [ADDR_W-1:0]            ch_queries_ptr,
  output logic [XFER_W-1:0]            ch_query_xfer_size_in_bytes,
  output logic                         cmpl_valid,
  input  logic                         cmpl_ready,
  output logic [7:0]                   cmpl_id,
  output logic                         cmpl_err,
  output logic                         busy,
  output logic [$clog2(Q_DEPTH):0]     q_level,
`ifdef ERBIUM_SCHED_PERF_EN
  output logic [31:0]                  cmpl_cycles,
`endif
  output logic [31:0]                  jobs_done
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [7:0]        id;
    logic [63:0]       hash;
    logic [ADDR_W-1:0] nfa_ptr;
    logic [XFER_W-1:0] nfa_bytes;
    logic [ADDR_W-1:0] qry_ptr;
    logic [XFER_W-1:0] qry_bytes;
  } job_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    REPORT = 3'd4
  } state_t;

  // Job storage: plain array, no reset, written only on accepted pushes.
  job_t             mem_q [Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             rdy_en_q;   // holds job_ready low until the first edge after reset

  state_t           state_q;
  job_t             head_q;     // registered copy of the queue head, drives ch_*
  logic             hash_valid_q;
  logic [63:0]      last_hash_q;
  logic             ch_start_q;
  logic             cmpl_valid_q;
  logic             cmpl_err_q;
  logic [7:0]       cmpl_id_q;
  logic [31:0]      jobs_done_q;
`ifdef ERBIUM_SCHED_PERF_EN
  logic [31:0]      cyc_q;
  logic [31:0]      cmpl_cycles_q;
  logic [31:0]      cyc_d;
`endif

  job_t job_in_d;
  logic push_d, pop_d, reload_d, err_d;

  always_comb begin
    job_in_d.id        = job_id;
    job_in_d.hash      = job_nfa_hash;
    job_in_d.nfa_ptr   = job_nfa_ptr;
    job_in_d.nfa_bytes = job_nfa_bytes;
    job_in_d.qry_ptr   = job_query_ptr;
    job_in_d.qry_bytes = job_query_bytes;
  end

  assign job_ready = rdy_en_q && (level_q < LVL_W'(Q_DEPTH));
  assign push_d    = job_valid && job_ready;
  // cmpl_valid is always high in REPORT, so the handshake reduces to this.
  assign pop_d     = (state_q == REPORT) && cmpl_ready;

  // Validity only depends on the NFA length when the channel must reload it.
  assign reload_d = !hash_valid_q || (head_q.hash != last_hash_q);
  assign err_d    = (head_q.qry_bytes == '0) || (head_q.qry_bytes[5:0] != 6'd0) ||
                    (reload_d && ((head_q.nfa_bytes == '0) ||
                                  (head_q.nfa_bytes[5:0] != 6'd0)));

`ifdef ERBIUM_SCHED_PERF_EN
  assign cyc_d = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
`endif

  always_ff @(posedge data_clk) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= job_in_d;
    end
  end

  always_ff @(posedge data_clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rdy_en_q      <= 1'b0;
      state_q       <= IDLE;
      head_q        <= '0;
      hash_valid_q  <= 1'b0;
      last_hash_q   <= '0;
      ch_start_q    <= 1'b0;
      cmpl_valid_q  <= 1'b0;
      cmpl_err_q    <= 1'b0;
      cmpl_id_q     <= '0;
      jobs_done_q   <= '0;
`ifdef ERBIUM_SCHED_PERF_EN
      cyc_q         <= '0;
      cmpl_cycles_q <= '0;
`endif
    end else begin
      rdy_en_q   <= 1'b1;
      ch_start_q <= 1'b0;

      if (push_d) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_d)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // Simultaneous push and pop leave the level unchanged.
      case ({push_d, pop_d})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase

      unique case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            head_q  <= mem_q[rd_ptr_q];
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (err_d) begin
            cmpl_valid_q  <= 1'b1;
            cmpl_err_q    <= 1'b1;
            cmpl_id_q     <= head_q.id;
`ifdef ERBIUM_SCHED_PERF_EN
            cmpl_cycles_q <= '0;
`endif
            state_q       <= REPORT;
          end else begin
            ch_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          // ch_done is deliberately not sampled here.
          last_hash_q  <= head_q.hash;
          hash_valid_q <= 1'b1;
`ifdef ERBIUM_SCHED_PERF_EN
          cyc_q        <= 32'd1;
`endif
          state_q      <= RUN;
        end
        RUN: begin
          if (ch_done) begin
            cmpl_valid_q  <= 1'b1;
            cmpl_err_q    <= 1'b0;
            cmpl_id_q     <= head_q.id;
`ifdef ERBIUM_SCHED_PERF_EN
            cmpl_cycles_q <= cyc_d;
`endif
            state_q       <= REPORT;
          end else begin
`ifdef ERBIUM_SCHED_PERF_EN
            cyc_q <= cyc_d;
`endif
          end
        end
        REPORT: begin
          if (cmpl_ready) begin
            cmpl_valid_q <= 1'b0;
            cmpl_err_q   <= 1'b0;
            jobs_done_q  <= jobs_done_q + 32'd1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_start                    = ch_start_q;
  assign ch_nfa_hash                 = head_q.hash;
  assign ch_nfadata_ptr              = head_q.nfa_ptr;
  assign ch_nfa_xfer_size_in_bytes   = head_q.nfa_bytes;
  assign ch_queries_ptr              = head_q.qry_ptr;
  assign ch_query_xfer_size_in_bytes = head_q.qry_bytes;
  assign cmpl_valid                  = cmpl_valid_q;
  assign cmpl_id                     = cmpl_id_q;
  assign cmpl_err                    = cmpl_err_q;
  assign busy                        = (state_q != IDLE);
  assign q_level                     = level_q;
  assign jobs_done                   = jobs_done_q;
`ifdef ERBIUM_SCHED_PERF_EN
  assign cmpl_cycles                 = cmpl_cycles_q;
`endif

endmodule
